// File: rtl/tree_cg_pkg.sv
// Shared types for the clock-tree root gate: FSM state encoding.
package tree_cg_pkg;

  typedef enum logic [1:0] {
    CG_OFF   = 2'd0,
    CG_WAKE  = 2'd1,
    CG_ON    = 2'd2,
    CG_DRAIN = 2'd3
  } cg_state_t;

endpackage

// File: rtl/cg_latch_cell.sv
// Glitch-free clock gate: low-transparent enable latch followed by an AND.
// Kept as its own module so synthesis can swap in an integrated clock-gating cell.
module cg_latch_cell (
  input  logic clk,
  input  logic en,
  input  logic test_en,
  output logic clk_gated
);

  logic en_latched;

  // Enable only changes while clk is low, so the AND never sees a mid-pulse edge.
  always_latch begin
    if (!clk) en_latched = en | test_en;
  end

  assign clk_gated = clk & en_latched;

endmodule

// File: rtl/tree_root_clock_gate.sv
// Handshaked clock gate feeding the buffer-tree root: wake window, ack, drain on busy.
// Optional activity counters are built when CLK_GATE_STATS_EN is defined.
module tree_root_clock_gate
  import tree_cg_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       test_en,
  input  logic       en_req,
  input  logic       busy,
  output logic       en_ack,
  output logic       clk_gated,
  output logic [1:0] state_o
`ifdef CLK_GATE_STATS_EN
  ,
  output logic [CNT_W-1:0] on_cycles,
  output logic [CNT_W-1:0] wake_count
`endif
);

  localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);

  if (WAKE_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("tree_root_clock_gate: WAKE_CYCLES and CNT_W must be >= 1");
  end

  cg_state_t          state;
  logic               gate_en;
  logic [WAKE_W-1:0]  wake_cnt;

  // Handshake FSM; gate_en and en_ack are updated alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CG_OFF;
      gate_en  <= 1'b0;
      en_ack   <= 1'b0;
      wake_cnt <= '0;
    end else begin
      case (state)
        CG_OFF: begin
          if (en_req) begin
            state    <= CG_WAKE;
            gate_en  <= 1'b1;
            wake_cnt <= WAKE_LOAD;
          end
        end
        CG_WAKE: begin
          if (!en_req) begin
            state <= CG_DRAIN;
          end else if (wake_cnt == '0) begin
            state  <= CG_ON;
            en_ack <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt - WAKE_W'(1);
          end
        end
        CG_ON: begin
          if (!en_req) begin
            state  <= CG_DRAIN;
            en_ack <= 1'b0;
          end
        end
        CG_DRAIN: begin
          // A returning request wins over busy: the tree is still clocked, so no re-wake.
          if (en_req) begin
            state  <= CG_ON;
            en_ack <= 1'b1;
          end else if (!busy) begin
            state   <= CG_OFF;
            gate_en <= 1'b0;
          end
        end
        default: begin
          state   <= CG_OFF;
          gate_en <= 1'b0;
          en_ack  <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

  cg_latch_cell u_gate (
    .clk       (clk),
    .en        (gate_en),
    .test_en   (test_en),
    .clk_gated (clk_gated)
  );

`ifdef CLK_GATE_STATS_EN
  // Saturating activity counters; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_cycles  <= '0;
      wake_count <= '0;
    end else begin
      if (gate_en && (on_cycles != '1)) on_cycles <= on_cycles + CNT_W'(1);
      if ((state == CG_OFF) && en_req && (wake_count != '1))
        wake_count <= wake_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tree_root_clock_gate.sv
// Scoreboard bench for tree_root_clock_gate: driver queues per-edge expectations, monitor checks.
module tb_tree_root_clock_gate;

  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic test_en = 1'b0;
  logic en_req = 1'b0;
  logic busy = 1'b0;
  logic en_ack;
  logic clk_gated;
  logic [1:0] state_o;
`ifdef CLK_GATE_STATS_EN
  logic [3:0] on_cycles;
  logic [3:0] wake_count;
`endif

  tree_root_clock_gate #(.WAKE_CYCLES(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .test_en   (test_en),
    .en_req    (en_req),
    .busy      (busy),
    .en_ack    (en_ack),
    .clk_gated (clk_gated),
    .state_o   (state_o)
`ifdef CLK_GATE_STATS_EN
    ,
    .on_cycles (on_cycles),
    .wake_count(wake_count)
`endif
  );

  always #HALF clk = ~clk;

  typedef struct {
    int st;
    int ack;
    int g;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Drive inputs in the low phase and queue what the next edge should produce:
  // state_o, en_ack, and clk_gated level during the following high phase.
  task automatic step(input logic r, input logic b, input logic t,
                      input int es, input int ea, input int eg);
    @(negedge clk);
    en_req  = r;
    busy    = b;
    test_en = t;
    exp_q.push_back('{es, ea, eg});
  endtask

  // Monitor: one expectation consumed per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state_o", int'(state_o), e.st);
        chk("en_ack", int'(en_ack), e.ack);
        chk("clk_gated_high_phase", int'(clk_gated), e.g);
      end
    end
  end

  // Pulse-shape monitor: every gated pulse must be a full clk high phase.
  initial begin
    time rise_t;
    rise_t = 0;
    forever begin
      @(posedge clk_gated);
      rise_t = $time;
      chk("gated_rise_with_clk", int'(clk), 1);
      @(negedge clk_gated);
      chk("gated_pulse_width", int'($time - rise_t), HALF);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state_o", int'(state_o), 0);
    chk("reset_en_ack", int'(en_ack), 0);
    rst_n = 1'b1;

    // Idle after reset: clock stays flat.
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);

    // Wake: WAKE at k, first gated pulse at k+1, ack at k+4; busy ignored in WAKE.
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 2, 1, 1);
    step(1, 1, 0, 2, 1, 1);

    // Drain held by busy, then off; gated clock stops one phase later.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 3, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // Abort during wake at cnt=2, then reassert in drain (priority over busy=0).
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 3, 0, 1);
    step(0, 1, 0, 3, 0, 1);
    step(1, 0, 0, 2, 1, 1);
    step(0, 0, 0, 3, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // Request toggling every cycle.
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 3, 0, 1);
    step(1, 0, 0, 2, 1, 1);
    step(0, 0, 0, 3, 0, 1);
    step(1, 0, 0, 2, 1, 1);
    step(0, 0, 0, 3, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // Test override in OFF: clock passes, FSM untouched.
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

`ifdef CLK_GATE_STATS_EN
    @(negedge clk);
    chk("wake_count", int'(wake_count), 3);
    chk("on_cycles_saturated", int'(on_cycles), 15);
`endif

    // Reach ON, then asynchronous reset in the low phase.
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 2, 1, 1);
    step(1, 0, 0, 2, 1, 1);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.push_back('{0, 0, 0});
    #1;
    chk("async_rst_state_o", int'(state_o), 0);
    chk("async_rst_en_ack", int'(en_ack), 0);
`ifdef CLK_GATE_STATS_EN
    chk("async_rst_wake_count", int'(wake_count), 0);
`endif
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
